// File: rtl/cpu_pkg.sv
// Shared CPU datapath constants so the destination-select mux and the register
// bank agree on widths and special register indices.
package cpu_pkg;

   localparam int CPU_DATA_W = 32;
   localparam int CPU_ADDR_W = 5;
   localparam int CPU_NREGS  = 2 ** CPU_ADDR_W;

   localparam logic [CPU_ADDR_W-1:0] REG_ZERO = 5'd0;
   localparam logic [CPU_ADDR_W-1:0] REG_SP   = 5'd29;
   localparam logic [CPU_ADDR_W-1:0] REG_FP   = 5'd30;
   localparam logic [CPU_ADDR_W-1:0] REG_RA   = 5'd31;

   localparam logic [CPU_DATA_W-1:0] SP_RESET_DEFAULT = 32'd227;

endpackage

// File: rtl/reg_fwd_sel.sv
// Per-port read value selector: index 0 reads as zero, and a same-cycle write
// to the requested index is forwarded ahead of the stale array value.
module reg_fwd_sel #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] rd_idx_i,
   input  logic [DATA_W-1:0] arr_val_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_idx_i,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic [DATA_W-1:0] val_o
);

   // Zero-index check comes first so forwarding can never leak a value into r0.
   always_comb begin
      val_o = arr_val_i;
      if (rd_idx_i == '0) begin
         val_o = '0;
      end else if (wr_en_i && (wr_idx_i == rd_idx_i)) begin
         val_o = wr_data_i;
      end
   end

endmodule

// File: rtl/reg_bank_wb.sv
// 32-entry register bank with write-back port, two registered read latches
// feeding the A/B operand registers, and a saturating committed-write counter.
module reg_bank_wb
   import cpu_pkg::*;
#(
   parameter int                 DATA_W   = CPU_DATA_W,
   parameter int                 ADDR_W   = CPU_ADDR_W,
   parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(SP_RESET_DEFAULT)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              reg_write,
   input  logic [ADDR_W-1:0] write_reg,
   input  logic [DATA_W-1:0] write_data,
   input  logic [ADDR_W-1:0] read_reg1,
   input  logic [ADDR_W-1:0] read_reg2,
   input  logic              rd_en,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   output logic [7:0]        wr_count
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] rdData1_q, rdData1_d;
   logic [DATA_W-1:0] rdData2_q, rdData2_d;
   logic [7:0]        wrCount_q, wrCount_d;
   logic              wrCommit;

   assign wrCommit = reg_write && (write_reg != '0);

   reg_fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel1 (
      .rd_idx_i  (read_reg1),
      .arr_val_i (regs_q[read_reg1]),
      .wr_en_i   (wrCommit),
      .wr_idx_i  (write_reg),
      .wr_data_i (write_data),
      .val_o     (rdData1_d)
   );

   reg_fwd_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_sel2 (
      .rd_idx_i  (read_reg2),
      .arr_val_i (regs_q[read_reg2]),
      .wr_en_i   (wrCommit),
      .wr_idx_i  (write_reg),
      .wr_data_i (write_data),
      .val_o     (rdData2_d)
   );

   always_comb begin
      wrCount_d = wrCount_q;
      if (wrCommit && (wrCount_q != 8'hFF)) begin
         wrCount_d = wrCount_q + 8'd1;
      end
   end

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
         end
      end else if (wrCommit) begin
         regs_q[write_reg] <= write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rdData1_q <= '0;
         rdData2_q <= '0;
         wrCount_q <= '0;
      end else begin
         wrCount_q <= wrCount_d;
         if (rd_en) begin
            rdData1_q <= rdData1_d;
            rdData2_q <= rdData2_d;
         end
      end
   end

   assign read_data1 = rdData1_q;
   assign read_data2 = rdData2_q;
   assign wr_count   = wrCount_q;

endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed plus randomized bench for reg_bank_wb, checked against a simple
// array-and-counter reference model.
module tb_reg_bank_wb;

   logic        clk;
   logic        reset_n;
   logic        reg_write;
   logic [4:0]  write_reg;
   logic [31:0] write_data;
   logic [4:0]  read_reg1;
   logic [4:0]  read_reg2;
   logic        rd_en;
   logic [31:0] read_data1;
   logic [31:0] read_data2;
   logic [7:0]  wr_count;

   logic [31:0] model [32];
   logic [31:0] expA;
   logic [31:0] expB;
   int          expCnt;
   int          total;
   int          bad;

   reg_bank_wb dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .reg_write  (reg_write),
      .write_reg  (write_reg),
      .write_data (write_data),
      .read_reg1  (read_reg1),
      .read_reg2  (read_reg2),
      .rd_en      (rd_en),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .wr_count   (wr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] readValue(input logic [4:0] idx, input logic rw,
                                             input logic [4:0] wreg, input logic [31:0] wdata);
      if (idx == 5'd0) return 32'd0;
      if (rw && wreg == idx) return wdata;
      return model[idx];
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
      model[29] = 32'd227;
      expA = 32'd0;
      expB = 32'd0;
      expCnt = 0;
   endtask

   // Drives one cycle, clocks it, and advances the reference model to match.
   task automatic applyStimulus(input logic rst, input logic rw, input logic [4:0] wreg,
                                input logic [31:0] wdata, input logic rde,
                                input logic [4:0] r1, input logic [4:0] r2);
      reset_n = rst;
      reg_write = rw;
      write_reg = wreg;
      write_data = wdata;
      rd_en = rde;
      read_reg1 = r1;
      read_reg2 = r2;
      @(posedge clk);
      #1;
      if (!rst) begin
         modelReset();
      end else begin
         if (rde) begin
            expA = readValue(r1, rw, wreg, wdata);
            expB = readValue(r2, rw, wreg, wdata);
         end
         if (rw && wreg != 5'd0) begin
            model[wreg] = wdata;
            if (expCnt < 255) expCnt++;
         end
      end
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".rd1"}, read_data1, expA);
      checkOutput({tag, ".rd2"}, read_data2, expB);
      checkOutput({tag, ".cnt"}, {24'd0, wr_count}, 32'(expCnt));
   endtask

   initial begin
      logic [4:0] wr;
      logic [4:0] a;
      logic [4:0] b;
      total = 0;
      bad = 0;
      modelReset();
      $display("[TB] starting reg_bank_wb test");

      applyStimulus(1'b0, 1'b1, 5'd29, 32'hFF, 1'b1, 5'd29, 5'd29);
      applyStimulus(1'b0, 1'b1, 5'd8, 32'h55, 1'b1, 5'd8, 5'd8);
      checkAll("reset");
      checkOutput("reset.rd1_zero", read_data1, 32'd0);

      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd29, 5'd5);
      checkAll("post_reset_read");
      checkOutput("sp_reset", read_data1, 32'd227);

      applyStimulus(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 5'd0);
      checkAll("write8");
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 5'd29);
      checkAll("read8");
      checkOutput("read8.literal", read_data1, 32'hDEADBEEF);

      applyStimulus(1'b1, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0);
      checkAll("zero_fwd");
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 5'd0);
      checkAll("zero_read");

      applyStimulus(1'b1, 1'b1, 5'd31, 32'h10, 1'b0, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b1, 5'd31, 32'h400, 1'b1, 5'd31, 5'd31);
      checkAll("fwd_both");
      checkOutput("fwd_both.literal", read_data2, 32'h400);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd31, 5'd31);
      checkAll("fwd_reread");

      applyStimulus(1'b1, 1'b1, 5'd31, 32'h777, 1'b0, 5'd31, 5'd31);
      checkAll("hold");
      checkOutput("hold.literal", read_data1, 32'h400);

      for (int i = 0; i < 60; i++) begin
         wr = 5'($urandom_range(0, 31));
         a = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
         b = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
         applyStimulus(1'b1, 1'($urandom_range(0, 1)), wr, $urandom,
                       1'($urandom_range(0, 3) != 0), a, b);
         checkAll("random");
      end

      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'b1, 1'b1, 5'd9, 32'(i), 1'b0, 5'd0, 5'd0);
      end
      checkAll("saturate");
      checkOutput("saturate.literal", {24'd0, wr_count}, 32'd255);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd0);
      checkAll("read9");

      applyStimulus(1'b0, 1'b1, 5'd29, 32'hFF, 1'b0, 5'd0, 5'd0);
      applyStimulus(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd29, 5'd9);
      checkAll("reset_mid_write");
      checkOutput("reset_mid_write.sp", read_data1, 32'd227);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- 32-entry general-purpose register bank for the multicycle CPU datapath.
- Consumes the 5-bit destination index chosen by the destination-select mux (rt, rd, $ra=31, $sp=29, $fp=30) and writes back results.
- Provides two registered read ports that feed the A/B operand latches.
- Includes same-cycle write-to-read forwarding.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width; NREGS = 2**ADDR_W
- SP_RESET, 227, reset value of register 29 ($sp)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- reg_write  in  1  write enable for the write-back port
- write_reg  in  ADDR_W  destination index from the destination-select mux
- write_data  in  DATA_W  write-back value
- read_reg1  in  ADDR_W  rs index
- read_reg2  in  ADDR_W  rt index
- rd_en  in  1  capture enable for the read latches (A/B load)
- read_data1  out  DATA_W  registered rs value (A latch)
- read_data2  out  DATA_W  registered rt value (B latch)
- wr_count  out  8  number of committed writes, saturating

Behaviour:
- Reset is synchronous and active-low: sampled only on the rising edge of clk when reset_n=0.
- State on reset:
  - all registers cleared to 0, except reg 29 = SP_RESET;
  - read_data1 = read_data2 = 0;
  - wr_count = 0.
- Reset overrides any write or read in the same cycle.
- Reset asserted mid-operation discards the in-flight write; the next cycle after release starts clean.
- Write:
  - On a rising edge with reset_n=1, reg_write=1 and write_reg != 0, regs[write_reg] <= write_data.
  - The write is visible through the read latches in the same edge (see forwarding).
- Register 0:
  - hardwired to 0; writes to index 0 are dropped silently;
  - reads of index 0 always return 0, including when forwarding matches index 0.
- Read latches:
  - On a rising edge with rd_en=1, read_data1 <= value(read_reg1) and read_data2 <= value(read_reg2).
  - With rd_en=0 both latches hold.
  - Latency: 1 clock from address and rd_en to output.
- Forwarding:
  - Applies when rd_en=1, reg_write=1, write_reg != 0 and write_reg == read_regN in the same cycle.
  - The latch captures write_data, not the stale array value.
  - Applies independently per port; both ports may forward simultaneously.
- wr_count:
  - increments by 1 on each committed write (reg_write=1, write_reg != 0, reset_n=1);
  - saturates at 255 and does not wrap;
  - writes to reg 0 do not count.
- Simultaneous events: read and write of different indices in one cycle are independent; the read returns the pre-write array value.
- No X propagation: all outputs are defined from the first post-reset edge.

Decomposition:
- Shared cpu_pkg holds:
  - REG_ZERO=0, REG_SP=29, REG_FP=30, REG_RA=31;
  - SP_RESET default;
  - DATA_W/ADDR_W constants, so the destination-select mux and this bank agree on special indices.
- One sub-module: reg_fwd_sel. It is a combinational per-port selector (index, array value, write signals -> value) with the zero-index and forwarding rules, instantiated twice.

Test Plan:
- Reset:
  - Stimulus: reset_n=0 for 2 edges, then release; rd_en=1 with read_reg1=29, read_reg2=5.
  - Required: read_data1=227 and read_data2=0 after 1 edge; wr_count=0.
- Basic write/read:
  - Stimulus: write reg 8 = 0xDEADBEEF; next cycle rd_en=1 with read_reg1=8.
  - Required: read_data1=0xDEADBEEF one edge later; wr_count=1.
- Zero register:
  - Stimulus: write reg 0 = 0x12345678; then read reg 0 on both ports, including same-cycle forwarding.
  - Required: both ports read 0; wr_count unchanged.
- Forwarding:
  - Stimulus: reg 31 holds 0x10; in the same cycle reg_write=1, write_reg=31, write_data=0x400 and rd_en=1, read_reg1=read_reg2=31.
  - Required: both outputs 0x400 after that edge; read again next cycle -> 0x400.
- Hold and saturation:
  - Stimulus: rd_en=0 while writing the latched index.
  - Required: outputs unchanged.
  - Stimulus: 300 consecutive writes to reg 9.
  - Required: wr_count=255.
- Reset mid-write:
  - Stimulus: reg_write=1, write_reg=29, write_data=0xFF with reset_n=0 on the same edge.
  - Required: reg 29 reads 227 afterward; wr_count=0.
